// File: rtl/crossbar_pkg.sv
// Shared definitions for the ReRAM crossbar write-side controller and the
// compute datapath: default array geometry, controller states, response codes.
package crossbar_pkg;

    // Default array geometry, shared with the crossbar compute datapath
    localparam int unsigned XBAR_ROWS    = 32;
    localparam int unsigned XBAR_COLS    = 32;
    localparam int unsigned XBAR_LEVEL_W = 4;

    // Program-and-verify controller states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        EVAL   = 3'd2,
        PULSE  = 3'd3,
        SETTLE = 3'd4,
        RESP   = 3'd5
    } state_t;

    // Response error codes
    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_BUDGET = 2'd1,
        ERR_TMO    = 2'd2,
        ERR_ADDR   = 2'd3
    } rsp_err_t;

    // Index width for n items; never collapses to zero bits
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xbar_onehot_dec.sv
// Binary index to one-hot decoder with enable.
// Ports:
//   en       - when low the output is all zeros
//   idx      - binary line index
//   onehot_c - one-hot line select (combinational); zero for idx >= N
module xbar_onehot_dec #(
    parameter int unsigned N  = 32,
    parameter int unsigned IW = 5
) (
    input  logic          en,
    input  logic [IW-1:0] idx,
    output logic [N-1:0]  onehot_c
);

    // Each line compares against its own index, so out-of-range indices decode to zero
    always_comb begin
        onehot_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            onehot_c[i] = en && (idx == IW'(i));
        end
    end

endmodule

// File: rtl/crossbar_prog_ctrl.sv
// Write-side controller for the ReRAM crossbar. Accepts one cell-programming
// request and runs a program-and-verify loop: sense, compare against the
// target level, apply a SET or RESET pulse, settle, re-sense. Reports
// success / budget exhaustion / read timeout / bad address via valid/ready.
// Ports:
//   wb_clk_i, wb_rst_i          - clock, asynchronous active-high reset
//   req_valid/req_ready         - request handshake; req_row/col/level payload
//   wl_sel, bl_sel              - one-hot word/bit-line selects (READ, PULSE only)
//   set_en, reset_en            - pulse drives (raise / lower conductance)
//   read_en, rd_valid, rd_level - verify-read request and sensed result
//   rsp_valid/rsp_ready         - response handshake; rsp_ok/err/pulses payload
//   busy                        - controller not idle
// All outputs are registered; they are computed from the next state so they
// line up with the state register.
module crossbar_prog_ctrl
    import crossbar_pkg::*;
#(
    parameter int unsigned ROWS       = XBAR_ROWS,
    parameter int unsigned COLS       = XBAR_COLS,
    parameter int unsigned LEVEL_W    = XBAR_LEVEL_W,
    parameter int unsigned TOL        = 0,
    parameter int unsigned PULSE_CYC  = 8,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned MAX_PULSES = 15,
    parameter int unsigned READ_TMO   = 64
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_i,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [idx_w(ROWS)-1:0]            req_row,
    input  logic [idx_w(COLS)-1:0]            req_col,
    input  logic [LEVEL_W-1:0]                req_level,
    output logic [ROWS-1:0]                   wl_sel,
    output logic [COLS-1:0]                   bl_sel,
    output logic                              set_en,
    output logic                              reset_en,
    output logic                              read_en,
    input  logic                              rd_valid,
    input  logic [LEVEL_W-1:0]                rd_level,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_ok,
    output logic [1:0]                        rsp_err,
    output logic [$clog2(MAX_PULSES+1)-1:0]   rsp_pulses,
    output logic                              busy
);

    localparam int unsigned RW      = idx_w(ROWS);
    localparam int unsigned CW      = idx_w(COLS);
    localparam int unsigned PW      = $clog2(MAX_PULSES + 1);
    localparam int unsigned TW      = $clog2(READ_TMO + 1);
    localparam int unsigned CYC_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int unsigned CYW     = $clog2(CYC_MAX + 1);

    state_t               state_q, state_d;
    logic [RW-1:0]        row_q, row_d;
    logic [CW-1:0]        col_q, col_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [LEVEL_W-1:0]   sense_q, sense_d;
    logic                 dir_set_q, dir_set_d;
    logic [PW-1:0]        pulses_q, pulses_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [CYW-1:0]       cyc_q, cyc_d;

    logic                 rsp_ok_d;
    logic [1:0]           rsp_err_d;
    logic [PW-1:0]        rsp_pulses_d;

    logic                 addr_bad_c;
    logic [LEVEL_W-1:0]   diff_c;
    logic                 within_tol_c;
    logic                 sel_en_c;
    logic [ROWS-1:0]      wl_sel_c;
    logic [COLS-1:0]      bl_sel_c;

    // Widen before comparing so non-power-of-two geometries are checked exactly
    assign addr_bad_c = (32'(req_row) >= ROWS) || (32'(req_col) >= COLS);

    // Unsigned absolute difference without wrap-around
    assign diff_c       = (sense_q >= level_q) ? (sense_q - level_q) : (level_q - sense_q);
    assign within_tol_c = (32'(diff_c) <= TOL);

    // Selects follow the next state so the registered copies match the state
    assign sel_en_c = (state_d == READ) || (state_d == PULSE);

    xbar_onehot_dec #(
        .N  (ROWS),
        .IW (RW)
    ) u_wl_dec (
        .en       (sel_en_c),
        .idx      (row_d),
        .onehot_c (wl_sel_c)
    );

    xbar_onehot_dec #(
        .N  (COLS),
        .IW (CW)
    ) u_bl_dec (
        .en       (sel_en_c),
        .idx      (col_d),
        .onehot_c (bl_sel_c)
    );

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        level_d      = level_q;
        sense_d      = sense_q;
        dir_set_d    = dir_set_q;
        pulses_d     = pulses_q;
        tmo_d        = tmo_q;
        cyc_d        = cyc_q;
        rsp_ok_d     = rsp_ok;
        rsp_err_d    = rsp_err;
        rsp_pulses_d = rsp_pulses;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    row_d    = req_row;
                    col_d    = req_col;
                    level_d  = req_level;
                    pulses_d = '0;
                    tmo_d    = '0;
                    cyc_d    = '0;
                    if (addr_bad_c) begin
                        state_d      = RESP;
                        rsp_ok_d     = 1'b0;
                        rsp_err_d    = ERR_ADDR;
                        rsp_pulses_d = '0;
                    end else begin
                        state_d = READ;
                    end
                end
            end

            READ: begin
                // A result on the last allowed cycle still wins over the timeout
                if (rd_valid) begin
                    sense_d = rd_level;
                    state_d = EVAL;
                end else if (tmo_q == TW'(READ_TMO - 1)) begin
                    state_d      = RESP;
                    rsp_ok_d     = 1'b0;
                    rsp_err_d    = ERR_TMO;
                    rsp_pulses_d = pulses_q;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            EVAL: begin
                if (within_tol_c) begin
                    state_d      = RESP;
                    rsp_ok_d     = 1'b1;
                    rsp_err_d    = ERR_NONE;
                    rsp_pulses_d = pulses_q;
                end else if (pulses_q == PW'(MAX_PULSES)) begin
                    state_d      = RESP;
                    rsp_ok_d     = 1'b0;
                    rsp_err_d    = ERR_BUDGET;
                    rsp_pulses_d = pulses_q;
                end else begin
                    dir_set_d = (sense_q < level_q);
                    pulses_d  = pulses_q + 1'b1;
                    cyc_d     = '0;
                    state_d   = PULSE;
                end
            end

            PULSE: begin
                if (cyc_q == CYW'(PULSE_CYC - 1)) begin
                    cyc_d   = '0;
                    state_d = SETTLE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            SETTLE: begin
                if (cyc_q == CYW'(SETTLE_CYC - 1)) begin
                    cyc_d   = '0;
                    tmo_d   = '0;
                    state_d = READ;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d      = IDLE;
                    rsp_ok_d     = 1'b0;
                    rsp_err_d    = ERR_NONE;
                    rsp_pulses_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset drops every drive at once
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            level_q    <= '0;
            sense_q    <= '0;
            dir_set_q  <= 1'b0;
            pulses_q   <= '0;
            tmo_q      <= '0;
            cyc_q      <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            read_en    <= 1'b0;
            set_en     <= 1'b0;
            reset_en   <= 1'b0;
            wl_sel     <= '0;
            bl_sel     <= '0;
            rsp_valid  <= 1'b0;
            rsp_ok     <= 1'b0;
            rsp_err    <= ERR_NONE;
            rsp_pulses <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            level_q    <= level_d;
            sense_q    <= sense_d;
            dir_set_q  <= dir_set_d;
            pulses_q   <= pulses_d;
            tmo_q      <= tmo_d;
            cyc_q      <= cyc_d;
            req_ready  <= (state_d == IDLE);
            busy       <= (state_d != IDLE);
            read_en    <= (state_d == READ);
            set_en     <= (state_d == PULSE) && dir_set_d;
            reset_en   <= (state_d == PULSE) && !dir_set_d;
            wl_sel     <= wl_sel_c;
            bl_sel     <= bl_sel_c;
            rsp_valid  <= (state_d == RESP);
            rsp_ok     <= rsp_ok_d;
            rsp_err    <= rsp_err_d;
            rsp_pulses <= rsp_pulses_d;
        end
    end

endmodule

// File: tb/tb_crossbar_prog_ctrl.sv
// Directed bench for crossbar_prog_ctrl. ROWS is set to 40 so that row=40 is
// representable on req_row and exercises the out-of-range path.
module tb_crossbar_prog_ctrl;

    localparam int unsigned ROWS       = 40;
    localparam int unsigned COLS       = 32;
    localparam int unsigned LEVEL_W    = 4;
    localparam int unsigned PULSE_CYC  = 8;
    localparam int unsigned SETTLE_CYC = 4;
    localparam int unsigned MAX_PULSES = 15;
    localparam int unsigned READ_TMO   = 64;
    localparam int unsigned RW         = $clog2(ROWS);
    localparam int unsigned CW         = $clog2(COLS);
    localparam int unsigned PW         = $clog2(MAX_PULSES + 1);

    logic                wb_clk_i = 1'b0;
    logic                wb_rst_i;
    logic                req_valid;
    logic                req_ready;
    logic [RW-1:0]       req_row;
    logic [CW-1:0]       req_col;
    logic [LEVEL_W-1:0]  req_level;
    logic [ROWS-1:0]     wl_sel;
    logic [COLS-1:0]     bl_sel;
    logic                set_en;
    logic                reset_en;
    logic                read_en;
    logic                rd_valid;
    logic [LEVEL_W-1:0]  rd_level;
    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_ok;
    logic [1:0]          rsp_err;
    logic [PW-1:0]       rsp_pulses;
    logic                busy;

    int nvec = 0;
    int nerr = 0;

    // Activity monitor counters (written only by the monitor process)
    int n_set = 0, n_reset = 0, n_read = 0, n_rspv = 0, n_sel = 0;
    int both_hot = 0, multi_hot = 0, stray_sel = 0, bad_width = 0, bad_gap = 0;
    int pw_run = 0, gap = 0;
    bit in_gap = 1'b0;

    crossbar_prog_ctrl #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .LEVEL_W    (LEVEL_W),
        .TOL        (0),
        .PULSE_CYC  (PULSE_CYC),
        .SETTLE_CYC (SETTLE_CYC),
        .MAX_PULSES (MAX_PULSES),
        .READ_TMO   (READ_TMO)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_row    (req_row),
        .req_col    (req_col),
        .req_level  (req_level),
        .wl_sel     (wl_sel),
        .bl_sel     (bl_sel),
        .set_en     (set_en),
        .reset_en   (reset_en),
        .read_en    (read_en),
        .rd_valid   (rd_valid),
        .rd_level   (rd_level),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_ok     (rsp_ok),
        .rsp_err    (rsp_err),
        .rsp_pulses (rsp_pulses),
        .busy       (busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Watches drives mid-cycle: pulse counts/widths, settle gaps, select invariants
    always @(negedge wb_clk_i) begin
        if (wb_rst_i) begin
            pw_run = 0;
            in_gap = 1'b0;
        end else begin
            if (set_en && reset_en) both_hot++;
            if ($countones(wl_sel) > 1 || $countones(bl_sel) > 1) multi_hot++;
            if ((wl_sel != '0 || bl_sel != '0) && !(read_en || set_en || reset_en)) stray_sel++;
            if (wl_sel != '0 || bl_sel != '0) n_sel++;
            if (read_en) n_read++;
            if (rsp_valid) n_rspv++;
            if (set_en || reset_en) begin
                if (pw_run == 0) begin
                    if (set_en) n_set++;
                    else n_reset++;
                end
                pw_run++;
                in_gap = 1'b0;
            end else begin
                if (pw_run != 0) begin
                    if (pw_run != int'(PULSE_CYC)) bad_width++;
                    pw_run = 0;
                    in_gap = 1'b1;
                    gap    = 0;
                end
                if (in_gap) begin
                    if (read_en) begin
                        if (gap != int'(SETTLE_CYC)) bad_gap++;
                        in_gap = 1'b0;
                    end else begin
                        gap++;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single clock edge (called at a negedge)
    task automatic send_req(input logic [RW-1:0] row, input logic [CW-1:0] col,
                            input logic [LEVEL_W-1:0] lvl);
        req_valid = 1'b1;
        req_row   = row;
        req_col   = col;
        req_level = lvl;
        @(negedge wb_clk_i);
        req_valid = 1'b0;
    endtask

    task automatic wait_read(input string tag);
        for (int k = 0; k < 200 && read_en !== 1'b1; k++) @(negedge wb_clk_i);
        check(tag, 64'(read_en), 64'd1);
    endtask

    task automatic serve(input logic [LEVEL_W-1:0] lvl);
        rd_valid = 1'b1;
        rd_level = lvl;
        @(negedge wb_clk_i);
        rd_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag);
        for (int k = 0; k < 200 && rsp_valid !== 1'b1; k++) @(negedge wb_clk_i);
        check(tag, 64'(rsp_valid), 64'd1);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ROWS-1:0] exp_wl;
        logic [COLS-1:0] exp_bl;
        logic [LEVEL_W-1:0] conv [4];
        int s_set, s_reset, s_read, s_rspv, s_sel, s_bw, s_bg;

        wb_rst_i  = 1'b1;
        req_valid = 1'b0;
        req_row   = '0;
        req_col   = '0;
        req_level = '0;
        rd_valid  = 1'b0;
        rd_level  = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge wb_clk_i);

        // Reset state
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_drives",    64'({set_en, reset_en, read_en, rsp_valid}), 64'd0);
        check("rst_sel",       64'(wl_sel) | 64'(bl_sel), 64'd0);
        check("rst_rsp",       64'({rsp_ok, rsp_err, rsp_pulses}), 64'd0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);

        // Already on target
        s_set = n_set; s_reset = n_reset;
        send_req(RW'(3), CW'(5), 4'd7);
        wait_read("t1_read");
        exp_wl = '0; exp_wl[3] = 1'b1;
        exp_bl = '0; exp_bl[5] = 1'b1;
        check("t1_wl_sel", 64'(wl_sel), 64'(exp_wl));
        check("t1_bl_sel", 64'(bl_sel), 64'(exp_bl));
        check("t1_busy",   64'(busy),   64'd1);
        serve(4'd7);
        wait_resp("t1_resp");
        check("t1_ok_err_pulses", 64'({rsp_ok, rsp_err, rsp_pulses}), 64'({1'b1, 2'd0, 4'd0}));
        check("t1_no_pulse", 64'(n_set - s_set + n_reset - s_reset), 64'd0);
        handshake();
        check("t1_ready_after", 64'(req_ready), 64'd1);

        // Converge upward: 6,7,8,9 -> three SET pulses
        s_set = n_set; s_reset = n_reset; s_bw = bad_width; s_bg = bad_gap;
        conv[0] = 4'd6; conv[1] = 4'd7; conv[2] = 4'd8; conv[3] = 4'd9;
        send_req(RW'(10), CW'(20), 4'd9);
        for (int i = 0; i < 4; i++) begin
            wait_read("t2_read");
            serve(conv[i]);
        end
        wait_resp("t2_resp");
        check("t2_ok_err_pulses", 64'({rsp_ok, rsp_err, rsp_pulses}), 64'({1'b1, 2'd0, 4'd3}));
        check("t2_set_pulses",   64'(n_set - s_set),     64'd3);
        check("t2_reset_pulses", 64'(n_reset - s_reset), 64'd0);
        check("t2_pulse_width",  64'(bad_width - s_bw),  64'd0);
        check("t2_settle_gap",   64'(bad_gap - s_bg),    64'd0);
        handshake();

        // Budget exhaustion: target 2, sense always 10
        s_set = n_set; s_reset = n_reset; s_bw = bad_width;
        send_req(RW'(0), CW'(31), 4'd2);
        for (int i = 0; i < 16; i++) begin
            wait_read("t3_read");
            serve(4'd10);
        end
        wait_resp("t3_resp");
        check("t3_ok_err_pulses", 64'({rsp_ok, rsp_err, rsp_pulses}), 64'({1'b0, 2'd1, 4'd15}));
        check("t3_reset_pulses", 64'(n_reset - s_reset), 64'd15);
        check("t3_set_pulses",   64'(n_set - s_set),     64'd0);
        check("t3_pulse_width",  64'(bad_width - s_bw),  64'd0);
        handshake();

        // Read timeout
        s_set = n_set; s_reset = n_reset; s_read = n_read;
        send_req(RW'(39), CW'(0), 4'd5);
        wait_resp("t4_resp");
        check("t4_ok_err_pulses", 64'({rsp_ok, rsp_err, rsp_pulses}), 64'({1'b0, 2'd2, 4'd0}));
        check("t4_read_cycles", 64'(n_read - s_read), 64'(READ_TMO));
        check("t4_no_pulse", 64'(n_set - s_set + n_reset - s_reset), 64'd0);
        handshake();

        // Address error with response backpressure
        s_sel = n_sel; s_read = n_read;
        send_req(RW'(40), CW'(5), 4'd3);
        wait_resp("t5_resp");
        check("t5_ok_err_pulses", 64'({rsp_ok, rsp_err, rsp_pulses}), 64'({1'b0, 2'd3, 4'd0}));
        for (int i = 0; i < 5; i++) begin
            @(negedge wb_clk_i);
            check("t5_hold", 64'({rsp_valid, rsp_ok, rsp_err, rsp_pulses, req_ready}),
                  64'({1'b1, 1'b0, 2'd3, 4'd0, 1'b0}));
        end
        check("t5_no_sel",  64'(n_sel - s_sel),   64'd0);
        check("t5_no_read", 64'(n_read - s_read), 64'd0);
        handshake();
        check("t5_ready_after", 64'({req_ready, rsp_valid, busy}), 64'({1'b1, 1'b0, 1'b0}));

        // Reset during the third cycle of a SET pulse
        s_rspv = n_rspv;
        send_req(RW'(2), CW'(2), 4'd9);
        wait_read("t6_read");
        serve(4'd6);
        for (int k = 0; k < 50 && set_en !== 1'b1; k++) @(negedge wb_clk_i);
        check("t6_pulse_seen", 64'(set_en), 64'd1);
        repeat (2) @(negedge wb_clk_i);
        #1 wb_rst_i = 1'b1;
        #1;
        check("t6_drop", 64'({set_en, reset_en}) | 64'(wl_sel) | 64'(bl_sel), 64'd0);
        check("t6_ready_rst", 64'(req_ready), 64'd1);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        repeat (10) @(negedge wb_clk_i);
        check("t6_no_resp", 64'(n_rspv - s_rspv), 64'd0);

        // Next request after reset completes normally
        send_req(RW'(7), CW'(2), 4'd4);
        wait_read("t7_read");
        serve(4'd4);
        wait_resp("t7_resp");
        check("t7_ok_err_pulses", 64'({rsp_ok, rsp_err, rsp_pulses}), 64'({1'b1, 2'd0, 4'd0}));
        handshake();

        // Whole-run invariants
        check("inv_both_hot",  64'(both_hot),  64'd0);
        check("inv_multi_hot", 64'(multi_hot), 64'd0);
        check("inv_stray_sel", 64'(stray_sel), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/crossbar_prog_ctrl.md
Name: crossbar_prog_ctrl

Overview:
Write-side controller for the ReRAM crossbar array; the compute/read datapath is the other end. It accepts one cell-programming request (row, column, target conductance level) and runs an iterative program-and-verify loop: sense the cell, compare with the target, apply a SET or RESET pulse, settle, and re-sense. It reports success, failure or error to the management-side logic through a valid/ready response.

Parameters:
ROWS, 32, word lines in the array
COLS, 32, bit lines in the array
LEVEL_W, 4, width of quantised conductance level
TOL, 0, allowed |sensed - target| for success
PULSE_CYC, 8, SET/RESET pulse width in clocks (>=1)
SETTLE_CYC, 4, post-pulse settle time in clocks (>=1)
MAX_PULSES, 15, pulse budget per request
READ_TMO, 64, clocks to wait for rd_valid before abort

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  asynchronous active-high reset
req_valid  in  1  program request valid
req_ready  out  1  controller can accept a request
req_row  in  $clog2(ROWS)  target word line
req_col  in  $clog2(COLS)  target bit line
req_level  in  LEVEL_W  target conductance level
wl_sel  out  ROWS  one-hot word-line select
bl_sel  out  COLS  one-hot bit-line select
set_en  out  1  SET pulse drive (raises conductance)
reset_en  out  1  RESET pulse drive (lowers conductance)
read_en  out  1  verify-read request to sense path
rd_valid  in  1  sensed level valid
rd_level  in  LEVEL_W  sensed level
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_ok  out  1  target reached within TOL
rsp_err  out  2  0 none, 1 pulse budget exhausted, 2 read timeout, 3 address out of range
rsp_pulses  out  $clog2(MAX_PULSES+1)  pulses applied
busy  out  1  state != IDLE

Behaviour:
- One clock, wb_clk_i. Reset is asynchronous and active-high on wb_rst_i. Reset drives every output to 0 and the state to IDLE. The exception is req_ready, which is 1 after reset.
- States: IDLE, READ, EVAL, PULSE, SETTLE, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch row, col and level, and clear the pulse and timeout counters.
  - row>=ROWS or col>=COLS: go to RESP with err=3, ok=0, pulses=0. No selects are ever driven.
  - Otherwise go to READ.
- READ:
  - read_en=1; wl_sel and bl_sel are one-hot on the latched cell.
  - rd_valid=1: register rd_level and go to EVAL.
  - Timeout counter reaches READ_TMO clocks without rd_valid: go to RESP with err=2.
  - rd_valid in any other state is ignored.
- EVAL (exactly 1 cycle, selects 0):
  - |rd_level - target| <= TOL, computed unsigned with no wrap: go to RESP, ok=1.
  - Else pulses==MAX_PULSES: go to RESP, err=1.
  - Else latch the direction (sensed<target means SET, else RESET) and go to PULSE.
- PULSE: selects driven and exactly one of set_en/reset_en high for exactly PULSE_CYC cycles. The pulse counter increments on entry. Then go to SETTLE.
- SETTLE: all drives 0 for exactly SETTLE_CYC cycles, then go to READ with the timeout counter cleared.
- RESP:
  - rsp_valid=1; rsp_ok, rsp_err and rsp_pulses are held stable until rsp_ready.
  - On the handshake go to IDLE. req_ready rises the following cycle, so there are no back-to-back accepts.
- Invariants:
  - set_en&&reset_en never both high.
  - wl_sel and bl_sel are zero outside READ and PULSE.
  - wl_sel and bl_sel are never multi-hot.
  - req_ready = (state==IDLE).
- Reset mid-PULSE: set_en and reset_en drop asynchronously and the in-flight request is discarded with no response.

Decomposition:
- Shared package crossbar_pkg holds:
  - State enum.
  - rsp_err codes (ERR_NONE, ERR_BUDGET, ERR_TMO, ERR_ADDR).
  - Default ROWS, COLS and LEVEL_W constants, shared with the crossbar compute datapath.
- One sub-module, xbar_onehot_dec: binary index to one-hot with an enable. Instantiated twice, once for wl_sel and once for bl_sel.

Test Plan:
- Already on target: req row=3 col=5 level=7; sense returns 7 on the first read -> rsp_ok=1, err=0, pulses=0; set_en and reset_en never asserted; wl_sel=1<<3, bl_sel=1<<5 during READ.
- Converge upward: target 9, sense sequence 6,7,8,9 -> 3 SET pulses, each exactly 8 cycles high followed by 4 idle cycles; rsp_ok=1, pulses=3.
- Budget exhaustion: target 2, sense always 10 -> 15 RESET pulses, then rsp_ok=0, err=1, pulses=15.
- Read timeout: rd_valid never asserted -> after 64 READ cycles, rsp_err=2, pulses=0; no pulse is ever driven.
- Address error plus backpressure: req row=40 -> rsp_err=3 with no selects driven. Hold rsp_ready=0 for 5 cycles -> response stable and req_ready=0. Handshake -> req_ready=1 on the next cycle.
- Reset mid-pulse: assert wb_rst_i during the 3rd PULSE cycle -> set_en, reset_en, wl_sel and bl_sel go to 0 in the same cycle; no rsp_valid; next request completes normally.
